// File: rtl/tetris_disp_ctrl_if.sv
// ---------------------------------------------------------------------------
// tetris_disp_ctrl_if
//   Bundle between the game core and the score display controller.
//   master : game core side. It drives the timebase, the live values,
//            hold and event requests, and it receives num/src/event_ack.
//   slave  : display controller side.
//   Signals:
//     tick       1  one-cycle timebase strobe
//     score      13 live score (source 0)
//     lines      13 live cleared-lines count (source 1)
//     level      13 live level (source 2)
//     hold       1  freezes rotation while high
//     event_req  1  one-cycle request to show event_val
//     event_val  13 event value, sampled with event_req
//     event_ack  1  one-cycle acknowledge, the cycle after event_req
//     num        13 registered value for the 7-segment driver
//     src        2  displayed source: 0 score, 1 lines, 2 level, 3 event
// ---------------------------------------------------------------------------
interface tetris_disp_ctrl_if;
  logic        tick;
  logic [12:0] score;
  logic [12:0] lines;
  logic [12:0] level;
  logic        hold;
  logic        event_req;
  logic [12:0] event_val;
  logic        event_ack;
  logic [12:0] num;
  logic [1:0]  src;

  modport master (
    output tick, score, lines, level, hold, event_req, event_val,
    input  event_ack, num, src
  );

  modport slave (
    input  tick, score, lines, level, hold, event_req, event_val,
    output event_ack, num, src
  );
endinterface

// File: rtl/tetris_disp_ctrl.sv
// ---------------------------------------------------------------------------
// tetris_disp_ctrl
//   Rotates the display between score, lines and level. Each source stays
//   on screen for DWELL tick strobes. An event request can preempt the
//   rotation to show an event value for FLASH ticks. After that the display
//   resumes at the state it left, with a fresh dwell.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  synchronous active-low reset
//     bus    tetris_disp_ctrl_if.slave (see interface file for signals)
//
//   Parameters:
//     DWELL  tick strobes per rotating source (>= 1)
//     FLASH  tick strobes per event display  (>= 1)
//
//   Build option:
//     TETRIS_DISP_EVENT_EN  when defined, event preemption is built in.
//                           When undefined, event_req and event_val are
//                           ignored, event_ack is tied low and src never
//                           reaches 3.
//
//   num and src change on the same edge. num is loaded from the source that
//   belongs to the state being entered, so a live input change shows up on
//   num one cycle later. The display ceiling is 9999. All sources are 13 bits
//   wide, so their maximum is 8191, and every value is already inside the
//   displayable range. No clamp stage is needed.
// ---------------------------------------------------------------------------
module tetris_disp_ctrl #(
  parameter int DWELL = 2000,
  parameter int FLASH = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  tetris_disp_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {
    S_SCORE = 2'd0,
    S_LINES = 2'd1,
    S_LEVEL = 2'd2,
    S_EVENT = 2'd3
  } state_t;

  // Counters are sized to hold their terminal count exactly.
  localparam int DW = $clog2(DWELL + 1);

  state_t          state_q;
  logic [DW-1:0]   dwell_q;
  logic [12:0]     num_q;

  state_t          rot_next;
  logic [DW-1:0]   dwell_inc;
  logic [12:0]     val_cur;
  logic [12:0]     val_rot;
  logic            dwell_step;

  function automatic logic [12:0] pick(input state_t s,
                                       input logic [12:0] sc,
                                       input logic [12:0] ln,
                                       input logic [12:0] lv);
    case (s)
      S_LINES: return ln;
      S_LEVEL: return lv;
      default: return sc;
    endcase
  endfunction

`ifdef TETRIS_DISP_EVENT_EN
  localparam int FW = $clog2(FLASH + 1);

  state_t          ret_q;
  logic [FW-1:0]   flash_q;
  logic [12:0]     ev_val_q;
  logic            ack_q;
  logic [FW-1:0]   flash_inc;
  logic [12:0]     val_ret;
`endif

  // NOTE: every signal written here gets a default value first, so a missed branch cannot infer a latch.
  always_comb begin
    rot_next   = S_SCORE;
    dwell_inc  = dwell_q;
    dwell_step = bus.tick & ~bus.hold;

    unique case (state_q)
      S_SCORE: rot_next = S_LINES;
      S_LINES: rot_next = S_LEVEL;
      S_LEVEL: rot_next = S_SCORE;
      S_EVENT: rot_next = S_SCORE;
    endcase

    // Saturating increment. The clear-on-terminal logic below normally keeps
    // the counter from getting here, but a wrap must never happen.
    if (dwell_q != DW'(DWELL)) dwell_inc = dwell_q + 1'b1;

    val_cur = pick(state_q,  bus.score, bus.lines, bus.level);
    val_rot = pick(rot_next, bus.score, bus.lines, bus.level);
  end

`ifdef TETRIS_DISP_EVENT_EN
  always_comb begin
    flash_inc = flash_q;
    if (flash_q != FW'(FLASH)) flash_inc = flash_q + 1'b1;
    val_ret = pick(ret_q, bus.score, bus.lines, bus.level);
  end
`endif

  // The whole FSM lives in one clocked block. Its outputs (num, ack) are
  // assigned alongside the state, so they are registered with it.
  // NOTE: sequential state uses non-blocking assignments only; every register sees pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, and every register, including the event payload, returns to a known value.
    if (!rst_n) begin
      state_q  <= S_SCORE;
      dwell_q  <= '0;
      num_q    <= '0;
`ifdef TETRIS_DISP_EVENT_EN
      ret_q    <= S_SCORE;
      flash_q  <= '0;
      ev_val_q <= '0;
      ack_q    <= 1'b0;
`endif
    end else begin
`ifdef TETRIS_DISP_EVENT_EN
      // Every request is accepted, so the ack is the request one cycle later.
      ack_q <= bus.event_req;
`endif
      unique case (state_q)
        S_EVENT: begin
`ifdef TETRIS_DISP_EVENT_EN
          if (bus.event_req) begin
            // A new event restarts the flash. The return state stays as saved.
            // A request wins over a flash expiry on the same tick.
            ev_val_q <= bus.event_val;
            flash_q  <= '0;
            num_q    <= bus.event_val;
          end else if (bus.tick && flash_inc == FW'(FLASH)) begin
            state_q <= ret_q;
            flash_q <= '0;
            dwell_q <= '0;
            num_q   <= val_ret;
          end else begin
            if (bus.tick) flash_q <= flash_inc;
            num_q <= ev_val_q;
          end
`else
          // This state cannot be reached in this build. Recover to the start of the rotation.
          state_q <= S_SCORE;
          dwell_q <= '0;
          num_q   <= bus.score;
`endif
        end

        default: begin
`ifdef TETRIS_DISP_EVENT_EN
          // A request wins over a dwell expiry. The state saved for the
          // return is the one before rotation.
          if (bus.event_req) begin
            ret_q    <= state_q;
            state_q  <= S_EVENT;
            flash_q  <= '0;
            ev_val_q <= bus.event_val;
            num_q    <= bus.event_val;
          end else
`endif
          if (dwell_step && dwell_inc == DW'(DWELL)) begin
            state_q <= rot_next;
            dwell_q <= '0;
            num_q   <= val_rot;
          end else begin
            if (dwell_step) dwell_q <= dwell_inc;
            num_q <= val_cur;
          end
        end
      endcase
    end
  end

  assign bus.src = state_q;
  assign bus.num = num_q;

`ifdef TETRIS_DISP_EVENT_EN
  assign bus.event_ack = ack_q;
`else
  assign bus.event_ack = 1'b0;
  // The event inputs are part of the shared bundle but have no function in this build.
  logic unused_event;
  assign unused_event = ^{bus.event_req, bus.event_val};
`endif

endmodule

// File: tb/tb_tetris_disp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tetris_disp_ctrl
//   Directed bench for tetris_disp_ctrl with DWELL=4 and FLASH=3. Each step
//   drives the inputs for one cycle and pushes the expected {src, num, ack}
//   onto a scoreboard. One ns after the next rising edge, the step pops the
//   entry and compares it. The event section follows TETRIS_DISP_EVENT_EN,
//   the same macro the design uses.
// ---------------------------------------------------------------------------
module tb_tetris_disp_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  tetris_disp_ctrl_if bus ();

  tetris_disp_ctrl #(
    .DWELL(4),
    .FLASH(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [1:0]  src;
    logic [12:0] num;
    logic        ack;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clocked step. It drives the inputs, queues the expectation, then
  // samples after the edge.
  task automatic cyc(input string tag, input logic t, input logic h,
                     input logic er, input logic [12:0] ev,
                     input logic [1:0] es, input logic [12:0] en, input logic ea);
    exp_t e;
    bus.tick      = t;
    bus.hold      = h;
    bus.event_req = er;
    bus.event_val = ev;
    e.tag = tag;
    e.src = es;
    e.num = en;
    e.ack = ea;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.tag, ".src"}, 13'(bus.src), 13'(e.src));
    check({e.tag, ".num"}, bus.num, e.num);
    check({e.tag, ".ack"}, 13'(bus.event_ack), 13'(e.ack));
  endtask

  // Plain ticking step with no hold and no event.
  task automatic run(input string tag, input logic [1:0] es, input logic [12:0] en);
    cyc(tag, 1'b1, 1'b0, 1'b0, 13'd0, es, en, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.tick      = 1'b0;
    bus.hold      = 1'b0;
    bus.event_req = 1'b0;
    bus.event_val = '0;
    bus.score     = 13'd123;
    bus.lines     = 13'd45;
    bus.level     = 13'd6;

    // Reset state. A request during reset must not produce an ack.
    cyc("rst0", 1'b0, 1'b0, 1'b0, 13'd0,   2'd0, 13'd0, 1'b0);
    cyc("rst1", 1'b1, 1'b0, 1'b1, 13'd500, 2'd0, 13'd0, 1'b0);

    // Full rotation. The first edge out of reset loads score. After reset the
    // block has already spent its reset cycles in S_SCORE, so only 3 more
    // score samples appear before the first rotation.
    rst_n = 1'b1;
    repeat (3) run("score", 2'd0, 13'd123);
    repeat (4) run("lines", 2'd1, 13'd45);
    repeat (4) run("level", 2'd2, 13'd6);
    repeat (4) run("score2", 2'd0, 13'd123);
    run("lines2", 2'd1, 13'd45);

    // Hold for 10 ticks in S_LINES. Then exactly 4 more ticks before level.
    repeat (10) cyc("hold", 1'b1, 1'b1, 1'b0, 13'd0, 2'd1, 13'd45, 1'b0);
    repeat (3) run("post_hold", 2'd1, 13'd45);
    run("post_hold_rot", 2'd2, 13'd6);

    // No tick means no advance. A live input change shows up one edge later.
    repeat (2) cyc("no_tick", 1'b0, 1'b0, 1'b0, 13'd0, 2'd2, 13'd6, 1'b0);
    bus.level = 13'd7;
    run("level_upd", 2'd2, 13'd7);

`ifdef TETRIS_DISP_EVENT_EN
    // The event shows for 3 ticks. Then level returns with a full 4-tick dwell.
    cyc("ev_enter", 1'b1, 1'b0, 1'b1, 13'd800, 2'd3, 13'd800, 1'b1);
    repeat (2) run("ev_flash", 2'd3, 13'd800);
    run("ev_exit", 2'd2, 13'd7);
    repeat (3) run("ev_dwell", 2'd2, 13'd7);
    run("ev_dwell_end", 2'd0, 13'd123);

    // Event on the tick where the dwell would expire. The return is to score.
    repeat (3) run("pre_coinc", 2'd0, 13'd123);
    cyc("dwell_coinc", 1'b1, 1'b0, 1'b1, 13'd800, 2'd3, 13'd800, 1'b1);
    repeat (2) run("flash", 2'd3, 13'd800);
    // Second event on the flash-expiry tick, with hold high. The new request wins.
    cyc("flash_coinc", 1'b1, 1'b1, 1'b1, 13'd50, 2'd3, 13'd50, 1'b1);
    cyc("ev_notick", 1'b0, 1'b0, 1'b0, 13'd0, 2'd3, 13'd50, 1'b0);
    repeat (2) run("flash2", 2'd3, 13'd50);
    run("ret_pre_rot", 2'd0, 13'd123);

    // Leave an event in progress for the reset check below.
    cyc("ev_mid", 1'b1, 1'b0, 1'b1, 13'd900, 2'd3, 13'd900, 1'b1);
`else
    // Event inputs must have no effect. The rotation continues normally.
    cyc("ev_ign0", 1'b1, 1'b0, 1'b1, 13'd800, 2'd2, 13'd7,   1'b0);
    cyc("ev_ign1", 1'b1, 1'b0, 1'b1, 13'd50,  2'd2, 13'd7,   1'b0);
    cyc("ev_ign2", 1'b1, 1'b0, 1'b1, 13'd50,  2'd0, 13'd123, 1'b0);
`endif

    // Reset takes priority over an active event and a new request.
    rst_n = 1'b0;
    cyc("rst_mid", 1'b1, 1'b0, 1'b1, 13'd111, 2'd0, 13'd0, 1'b0);
    rst_n = 1'b1;
    run("rst_rel", 2'd0, 13'd123);

    // Large values. A 13-bit source tops out at 8191, which is inside the
    // 0..9999 display range, so values pass through unchanged.
    bus.score = 13'd8000;
    cyc("score_big", 1'b0, 1'b0, 1'b0, 13'd0, 2'd0, 13'd8000, 1'b0);
    bus.score = 13'd8191;
    cyc("score_max", 1'b0, 1'b0, 1'b0, 13'd0, 2'd0, 13'd8191, 1'b0);

    check("sb_empty", 13'(sb_q.size()), 13'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
